regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath.
- Provides one byte-masked write port and NUM_RD synchronous read ports with write-to-read bypass.
- Includes a per-register pending scoreboard for hazard detection, and a sequential bulk-clear engine that zeroes the array without a reset.
- Sits between decode (reads, reservations) and writeback (writes).

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- sto  in  1  write enable.
- waddr  in  ADDR_W  write address.
- dataIn  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte-lane write enables; bit k covers dataIn[8k+7:8k].
- raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies slice [i*ADDR_W +: ADDR_W].
- rden  in  NUM_RD  per-port read enable.
- databus  out  NUM_RD*DATA_W  read data; port i occupies slice [i*DATA_W +: DATA_W].
- resv  in  1  reserve-destination strobe.
- resv_addr  in  ADDR_W  register being reserved.
- pend_vec  out  DEPTH  pending flag per register.
- clr_req  in  1  bulk-clear request.
- clr_busy  out  1  high while bulk-clear runs.
- wr_drop  out  1  one-cycle pulse when a write is discarded.

Behaviour:
- Reset (rst=0, asynchronous):
  - All registers are 0.
  - databus is 0.
  - pend_vec is 0.
  - FSM is in IDLE.
  - clr_busy = 0, wr_drop = 0.
  - Release of reset is sampled on the next rising clk.
- Write (FSM in IDLE, sto=1):
  - At the clk edge, reg[waddr] lanes with wbe[k]=1 take dataIn; other lanes hold.
  - sto=1 with wbe=0 is a legal no-op. It still clears pend.
- Read:
  - Synchronous, 1-cycle latency.
  - If rden[i]=1 at edge N, databus port i shows reg[raddr_i] after edge N.
  - If rden[i]=0, port i holds its previous value.
- Bypass: if the same edge also writes raddr_i, port i returns the merged word (new lanes per wbe, old lanes otherwise), never the stale value.
- Multiple ports may read the same address in the same cycle; all return the identical value.
- Scoreboard:
  - resv=1 sets pend_vec[resv_addr].
  - An accepted write clears pend_vec[waddr].
  - If resv and a write target the same address in the same cycle, set wins: the register is reserved for a new producer.
  - pend_vec updates at the edge and is visible the following cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1. At that edge the index counter loads 0, pend_vec clears entirely, and clr_busy goes 1 next cycle.
  - In CLEAR, each edge zeroes reg[idx] and increments idx.
  - After the edge that zeroes idx=DEPTH-1, the FSM returns to IDLE and clr_busy drops. Total duration: exactly DEPTH cycles.
- Activity during CLEAR:
  - sto=1 is discarded and wr_drop pulses for that cycle.
  - resv is ignored.
  - clr_req is ignored.
  - Reads proceed against the storage. A read of the address being zeroed on that same edge returns 0 (clear bypass).
- clr_req=1 together with sto=1 in IDLE: the write is dropped (wr_drop=1) and the clear starts.
- Reset asserted mid-clear: reset forces IDLE and all registers to 0 immediately.
- Address width is exact; there is no out-of-range address.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- When defined:
  - Register 0 is hardwired to 0; writes to address 0 have no effect.
  - Reads of address 0 return 0, including on a bypass.
  - pend_vec[0] is constant 0; resv to address 0 is ignored.
  - Writes to address 0 do not pulse wr_drop.
- When undefined: register 0 behaves like every other register.

Test Plan:
- Reset, then write 32'hABCD1234 to reg 3 with wbe=4'hF; next cycle read reg 3 on both ports -> both ports show 32'hABCD1234 one cycle after rden.
- reg 5 = 32'h11223344; write 32'hAABBCCDD with wbe=4'b0101 while port 0 reads reg 5 on the same edge -> port 0 shows 32'h11BB33DD (bypass); next read returns the same value.
- resv reg 2 -> pend_vec[2]=1; later write reg 2 -> 0. Then resv reg 4 and write reg 4 on the same edge -> pend_vec[4] remains 1.
- Fill all 8 registers; pulse clr_req -> clr_busy high exactly 8 cycles. A sto during CLEAR gives wr_drop=1 and no change. All reads afterwards return 0 and pend_vec=0.
- Assert rst=0 asynchronously mid-write and mid-clear -> databus, pend_vec and clr_busy go 0 without a clock edge; all registers read 0 after release.
- With REGFILE_R0_ZERO_EN defined: write 32'hDEADBEEF to reg 0 while reading reg 0 -> read returns 0; pend_vec[0] stays 0 after resv to reg 0.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bundles the register file's decode/writeback signals: write, read, reserve and clear controls.
// Latency: none, this file only groups wires.
// Backpressure: none; the slave accepts every strobe, and dropped writes show up on wr_drop.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  localparam int DEPTH = 1 << ADDR_W;

  logic                       sto;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          dataIn;
  logic [DATA_W/8-1:0]        wbe;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD-1:0]          rden;
  logic [NUM_RD*DATA_W-1:0]   databus;
  logic                       resv;
  logic [ADDR_W-1:0]          resv_addr;
  logic [DEPTH-1:0]           pend_vec;
  logic                       clr_req;
  logic                       clr_busy;
  logic                       wr_drop;

  modport master (
    output sto, waddr, dataIn, wbe, raddr, rden, resv, resv_addr, clr_req,
    input  databus, pend_vec, clr_busy, wr_drop
  );

  modport slave (
    input  sto, waddr, dataIn, wbe, raddr, rden, resv, resv_addr, clr_req,
    output databus, pend_vec, clr_busy, wr_drop
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file: one byte-masked write port, NUM_RD read ports with write bypass, pending scoreboard, bulk clear.
// Latency: reads are registered (1 cycle); pend_vec updates at the edge; a bulk clear takes exactly DEPTH cycles.
// Backpressure: none; writes during a clear, or alongside clr_req, are dropped and flagged on wr_drop. Macro REGFILE_R0_ZERO_EN hardwires register 0 to zero.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            idx, idx_nxt;
  logic                         clr_start;
  logic [DATA_W-1:0]            mem [DEPTH];
  logic [DATA_W-1:0]            wmerge;
  logic                         w_r0;
  logic                         wr_hit;
  logic                         wr_en;
  logic [ADDR_W-1:0]            rd_a;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_nxt;

  // A write is accepted only in IDLE with no clear starting this edge; the
  // hardwired-zero register swallows its writes silently.
  assign w_r0        = R0_ZERO && (rf.waddr == '0);
  assign wr_hit      = (state == IDLE) && rf.sto && !rf.clr_req;
  assign wr_en       = wr_hit && !w_r0;
  assign rf.wr_drop  = rst && rf.sto && !w_r0 && ((state == CLEAR) || rf.clr_req);
  assign rf.clr_busy = (state == CLEAR);

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Clear FSM next state: walk idx from 0 to DEPTH-1, one register per edge.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_start = 1'b0;
    case (state)
      IDLE: begin
        if (rf.clr_req) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        idx_nxt = idx + 1'b1;
        if (&idx) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Merge new byte lanes over the current word at the write address.
  always_comb begin
    wmerge = mem[rf.waddr];
    for (int k = 0; k < NB; k++) begin
      if (rf.wbe[k]) wmerge[8*k +: 8] = rf.dataIn[8*k +: 8];
    end
  end

  // Storage: cleared by reset or one entry per edge by the clear engine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else if (state == CLEAR) begin
      mem[idx] <= '0;
    end else if (wr_en) begin
      mem[rf.waddr] <= wmerge;
    end
  end

  // Per-port read value with same-edge bypass; later checks take priority.
  always_comb begin
    rd_a   = '0;
    rd_nxt = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a      = rf.raddr[i*ADDR_W +: ADDR_W];
      rd_nxt[i] = mem[rd_a];
      if (wr_en && (rd_a == rf.waddr))        rd_nxt[i] = wmerge;
      if ((state == CLEAR) && (rd_a == idx))  rd_nxt[i] = '0;
      if (R0_ZERO && (rd_a == '0))            rd_nxt[i] = '0;
    end
  end

  // Registered read ports; a port with rden low keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf.databus <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (rf.rden[i]) rf.databus[i*DATA_W +: DATA_W] <= rd_nxt[i];
      end
    end
  end

  // Pending scoreboard: accepted write clears, reserve sets (set wins), clear start wipes all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf.pend_vec <= '0;
    end else if (clr_start) begin
      rf.pend_vec <= '0;
    end else if (state == IDLE) begin
      if (wr_hit) rf.pend_vec[rf.waddr] <= 1'b0;
      if (rf.resv && !(R0_ZERO && (rf.resv_addr == '0))) rf.pend_vec[rf.resv_addr] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: scoreboard of expected read data plus inline flag checks.
// Latency: expectations are pushed when a read is driven and popped 1 cycle later.
// Backpressure: none; drops during clear are checked via wr_drop.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int NR = 2;
  localparam int DEPTH = 8;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  typedef struct {
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] mlast [NR];
  logic [7:0]  mpend;

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) rf ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  function automatic logic [31:0] port_out(input int p);
    return rf.databus[p*DW +: DW];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    return (R0Z && a == 3'd0) ? 32'h0 : mdl[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input logic [31:0] v, input string n);
    exp_t e;
    e.port = p;
    e.val = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (port_out(e.port) !== e.val) begin
        errors++;
        $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, port_out(e.port), e.val);
      end
    end
  endtask

  task automatic idle_in();
    rf.sto = 1'b0; rf.waddr = '0; rf.dataIn = '0; rf.wbe = '0;
    rf.raddr = '0; rf.rden = '0; rf.resv = 1'b0; rf.resv_addr = '0; rf.clr_req = 1'b0;
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    rf.sto = 1'b1; rf.waddr = a; rf.dataIn = d; rf.wbe = be;
    tick();
    rf.sto = 1'b0; rf.wbe = '0;
    if (!(R0Z && a == 3'd0)) mdl[a] = merge(mdl[a], d, be);
  endtask

  task automatic read_pair(input logic [2:0] a0, input logic [2:0] a1, input string n);
    rf.rden = 2'b11; rf.raddr = {a1, a0};
    mlast[0] = exp_rd(a0);
    mlast[1] = exp_rd(a1);
    push(0, mlast[0], n);
    push(1, mlast[1], n);
    tick();
    drain();
    rf.rden = 2'b00;
  endtask

  task automatic test_reset();
    idle_in();
    rf.sto = 1'b1; rf.clr_req = 1'b1;
    rst = 1'b0;
    #3;
    checks++; if (rf.databus !== '0) begin errors++; $display("FAIL reset_databus: got %h expected 0", rf.databus); end
    checks++; if (rf.pend_vec !== 8'h0) begin errors++; $display("FAIL reset_pend: got %h expected 0", rf.pend_vec); end
    checks++; if (rf.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rf.clr_busy); end
    checks++; if (rf.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_wr_drop: got %b expected 0", rf.wr_drop); end
    idle_in();
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    mpend = 8'h0;
    tick();
    checks++; if (rf.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", rf.clr_busy); end
  endtask

  task automatic test_write_read();
    write(3'd3, 32'hABCD1234, 4'hF);
    read_pair(3'd3, 3'd3, "write_read_same_addr");
  endtask

  task automatic test_bypass();
    write(3'd5, 32'h11223344, 4'hF);
    rf.sto = 1'b1; rf.waddr = 3'd5; rf.dataIn = 32'hAABBCCDD; rf.wbe = 4'b0101;
    rf.rden = 2'b01; rf.raddr = {3'd0, 3'd5};
    push(0, 32'h11BB33DD, "bypass_merge");
    tick();
    drain();
    mdl[5] = 32'h11BB33DD;
    rf.sto = 1'b0; rf.wbe = '0;
    push(0, 32'h11BB33DD, "after_bypass");
    push(1, 32'hABCD1234, "port1_hold");
    tick();
    drain();
    rf.rden = 2'b00;
  endtask

  task automatic test_scoreboard();
    rf.resv = 1'b1; rf.resv_addr = 3'd2;
    tick();
    rf.resv = 1'b0;
    checks++; if (rf.pend_vec !== 8'h04) begin errors++; $display("FAIL pend_set: got %h expected 04", rf.pend_vec); end
    write(3'd2, 32'h22222222, 4'hF);
    checks++; if (rf.pend_vec !== 8'h00) begin errors++; $display("FAIL pend_clear_by_write: got %h expected 00", rf.pend_vec); end
    rf.resv = 1'b1; rf.resv_addr = 3'd4;
    write(3'd4, 32'h44444444, 4'hF);
    rf.resv = 1'b0;
    checks++; if (rf.pend_vec !== 8'h10) begin errors++; $display("FAIL pend_set_wins: got %h expected 10", rf.pend_vec); end
    rf.resv = 1'b1; rf.resv_addr = 3'd6;
    tick();
    rf.resv = 1'b0;
    write(3'd6, 32'hFFFFFFFF, 4'h0);
    checks++; if (rf.pend_vec !== 8'h10) begin errors++; $display("FAIL pend_wbe0_clear: got %h expected 10", rf.pend_vec); end
    read_pair(3'd6, 3'd4, "wbe0_noop");
    write(3'd4, 32'h44444444, 4'hF);
  endtask

  task automatic test_clear();
    int busy_cnt;
    for (int i = 0; i < DEPTH; i++) write(3'(i), 32'h01010101 * (i + 1), 4'hF);
    for (int i = 0; i < 4; i++) read_pair(3'(i), 3'(7 - i), "fill_readback");
    rf.resv = 1'b1; rf.resv_addr = 3'd5;
    tick();
    rf.resv = 1'b0;
    rf.clr_req = 1'b1; rf.sto = 1'b1; rf.waddr = 3'd2; rf.dataIn = 32'hFFFFFFFF; rf.wbe = 4'hF;
    #1;
    checks++; if (rf.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_with_clr_req: got %b expected 1", rf.wr_drop); end
    busy_cnt = 0;
    tick();
    idle_in();
    if (rf.clr_busy) busy_cnt++;
    checks++; if (rf.pend_vec !== 8'h0) begin errors++; $display("FAIL clear_pend: got %h expected 0", rf.pend_vec); end
    rf.rden = 2'b11; rf.raddr = {3'd7, 3'd0};
    push(0, 32'h0, "clear_bypass");
    push(1, exp_rd(3'd7), "read_during_clear");
    tick();
    drain();
    if (rf.clr_busy) busy_cnt++;
    rf.rden = 2'b00;
    rf.sto = 1'b1; rf.waddr = 3'd7; rf.dataIn = 32'hDEADDEAD; rf.wbe = 4'hF;
    rf.resv = 1'b1; rf.resv_addr = 3'd3; rf.clr_req = 1'b1;
    #1;
    checks++; if (rf.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_in_clear: got %b expected 1", rf.wr_drop); end
    tick();
    idle_in();
    if (rf.clr_busy) busy_cnt++;
    for (int n = 0; n < 20 && rf.clr_busy; n++) begin
      tick();
      if (rf.clr_busy) busy_cnt++;
    end
    checks++; if (busy_cnt != DEPTH) begin errors++; $display("FAIL clear_duration: got %0d cycles expected %0d", busy_cnt, DEPTH); end
    checks++; if (rf.clr_busy !== 1'b0) begin errors++; $display("FAIL clear_done: got %b expected 0", rf.clr_busy); end
    checks++; if (rf.pend_vec !== 8'h0) begin errors++; $display("FAIL clear_resv_ignored: got %h expected 0", rf.pend_vec); end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 4; i++) read_pair(3'(i), 3'(i + 4), "after_clear");
    rf.sto = 1'b1; rf.waddr = 3'd1; rf.dataIn = 32'h5A5A5A5A; rf.wbe = 4'hF;
    #1;
    checks++; if (rf.wr_drop !== 1'b0) begin errors++; $display("FAIL no_drop_idle: got %b expected 0", rf.wr_drop); end
    tick();
    rf.sto = 1'b0;
    mdl[1] = 32'h5A5A5A5A;
    read_pair(3'd1, 3'd1, "write_after_clear");
  endtask

  task automatic test_async_reset();
    write(3'd3, 32'h33333333, 4'hF);
    rf.resv = 1'b1; rf.resv_addr = 3'd1;
    tick();
    rf.resv = 1'b0;
    read_pair(3'd3, 3'd1, "pre_reset_read");
    rf.sto = 1'b1; rf.waddr = 3'd4; rf.dataIn = 32'h77777777; rf.wbe = 4'hF;
    #2 rst = 1'b0;
    #1;
    checks++; if (rf.databus !== '0) begin errors++; $display("FAIL async_rst_write_databus: got %h expected 0", rf.databus); end
    checks++; if (rf.pend_vec !== 8'h0) begin errors++; $display("FAIL async_rst_write_pend: got %h expected 0", rf.pend_vec); end
    idle_in();
    tick();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    read_pair(3'd3, 3'd4, "after_rst_write");
    write(3'd6, 32'h66666666, 4'hF);
    rf.clr_req = 1'b1;
    tick();
    rf.clr_req = 1'b0;
    rf.rden = 2'b01; rf.raddr = {3'd0, 3'd6};
    push(0, 32'h66666666, "read_before_rst_clear");
    tick();
    drain();
    rf.rden = 2'b00;
    tick();
    checks++; if (rf.clr_busy !== 1'b1) begin errors++; $display("FAIL mid_clear_busy: got %b expected 1", rf.clr_busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rf.clr_busy !== 1'b0) begin errors++; $display("FAIL async_rst_clear_busy: got %b expected 0", rf.clr_busy); end
    checks++; if (rf.databus !== '0) begin errors++; $display("FAIL async_rst_clear_databus: got %h expected 0", rf.databus); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    tick();
    checks++; if (rf.clr_busy !== 1'b0) begin errors++; $display("FAIL after_rst_busy: got %b expected 0", rf.clr_busy); end
    for (int i = 0; i < 4; i++) read_pair(3'(i), 3'(i + 4), "after_rst_clear");
  endtask

  task automatic test_r0();
    logic [31:0] want;
    want = R0Z ? 32'h0 : 32'hDEADBEEF;
    rf.sto = 1'b1; rf.waddr = 3'd0; rf.dataIn = 32'hDEADBEEF; rf.wbe = 4'hF;
    rf.rden = 2'b01; rf.raddr = {3'd0, 3'd0};
    push(0, want, "r0_bypass");
    #1;
    checks++; if (rf.wr_drop !== 1'b0) begin errors++; $display("FAIL r0_wr_drop: got %b expected 0", rf.wr_drop); end
    tick();
    drain();
    idle_in();
    if (!R0Z) mdl[0] = 32'hDEADBEEF;
    rf.resv = 1'b1; rf.resv_addr = 3'd0;
    tick();
    rf.resv = 1'b0;
    checks++; if (rf.pend_vec[0] !== !R0Z) begin errors++; $display("FAIL r0_pend: got %b expected %b", rf.pend_vec[0], !R0Z); end
    read_pair(3'd0, 3'd0, "r0_read");
    write(3'd0, 32'h0BADF00D, 4'hF);
    checks++; if (rf.pend_vec !== 8'h0) begin errors++; $display("FAIL r0_pend_cleared: got %h expected 0", rf.pend_vec); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] wa, ra0, ra1, rsa, a;
    logic [31:0] d, nw, v;
    logic [3:0] be;
    logic [1:0] re;
    logic s, rs, wr_eff;
    mpend = rf.pend_vec === 8'h0 ? 8'h0 : 8'hxx;
    read_pair(3'd1, 3'd2, "b2b_init");
    for (int n = 0; n < 60; n++) begin
      s = 1'($urandom_range(0, 1)); wa = 3'($urandom_range(0, 7)); d = $urandom; be = 4'($urandom_range(0, 15));
      re = 2'($urandom_range(0, 3)); ra0 = 3'($urandom_range(0, 7)); ra1 = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0); rsa = 3'($urandom_range(0, 7));
      rf.sto = s; rf.waddr = wa; rf.dataIn = d; rf.wbe = be; rf.rden = re; rf.raddr = {ra1, ra0};
      rf.resv = rs; rf.resv_addr = rsa;
      wr_eff = s && !(R0Z && wa == 3'd0);
      nw = merge(mdl[wa], d, be);
      for (int p = 0; p < NR; p++) begin
        a = (p == 0) ? ra0 : ra1;
        if (re[p]) begin
          v = (wr_eff && a == wa) ? nw : mdl[a];
          if (R0Z && a == 3'd0) v = 32'h0;
          mlast[p] = v;
        end
        push(p, mlast[p], "b2b_read");
      end
      tick();
      drain();
      if (wr_eff) mdl[wa] = nw;
      if (s) mpend[wa] = 1'b0;
      if (rs && !(R0Z && rsa == 3'd0)) mpend[rsa] = 1'b1;
      checks++; if (rf.pend_vec !== mpend) begin errors++; $display("FAIL b2b_pend cycle %0d: got %h expected %h", n, rf.pend_vec, mpend); end
    end
    idle_in();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_async_reset();
    test_r0();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
